dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH, 4, write-buffer entries; power of two, 2..16.
REQ-002 Parameter: AW, 32, byte-address width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
REQ-005 MemWriteM  input  1  core store strobe for the current cycle.
REQ-006 ALUResult  input  AW  core data byte address, used for both loads and stores.
REQ-007 WriteData  input  32  core store data.
REQ-008 ReadData  output  32  load data returned to the core, combinational from ALUResult.
REQ-009 StallM  output  1  core must hold its memory-stage request; the store is not accepted this cycle.
REQ-010 mem_req  output  1  store request to backing memory.
REQ-011 mem_addr  output  AW  word-aligned store address, with bits [1:0] = 0.
REQ-012 mem_wdata  output  32  backing store data.
REQ-013 mem_ack  input  1  backing memory accepted the current request.
REQ-014 mem_raddr  output  AW  backing read address, equal to ALUResult.
REQ-015 mem_rdata  input  32  backing read data, combinational from mem_raddr.

Function
REQ-016 The block SHALL buffer core stores in a DEPTH-entry FIFO and drain them to backing memory in order.
- Each entry holds word address ALUResult[AW-1:2] and 32-bit data.
REQ-017 The FIFO SHALL accept a push when MemWriteM=1 and StallM=0; the push SHALL be visible from the next cycle.
REQ-018 StallM SHALL be 1 when the FIFO holds DEPTH entries and MemWriteM=1.
- The push is rejected even if a pop completes in the same cycle.
REQ-019 The drain FSM SHALL have two states, IDLE and BUSY.
- IDLE -> BUSY when the FIFO is non-empty at a clock edge.
- BUSY -> IDLE when mem_ack=1 and that entry is the last one, with no push in the same cycle.
- Otherwise BUSY holds.
REQ-020 In BUSY, mem_req SHALL be 1 and mem_addr/mem_wdata SHALL equal the head entry.
- These SHALL stay stable until mem_ack=1.
- The head SHALL be popped on the mem_ack=1 edge.
- The next entry, if any, SHALL be presented in the following cycle with no idle gap.
REQ-021 mem_req SHALL be 0 in IDLE; mem_ack while mem_req=0 SHALL be ignored.
REQ-022 Occupancy SHALL change as follows:
- simultaneous push and pop leaves occupancy unchanged;
- read and write pointers wrap modulo DEPTH;
- the occupancy counter is log2(DEPTH)+1 bits wide.
REQ-023 Address matching SHALL compare bits [AW-1:2] only; stores are full-word.
REQ-024 With no buffered match, ReadData SHALL equal mem_rdata.
REQ-025 Minimum store latency SHALL be 2 cycles: push edge, then mem_req on the next cycle.

Reset
REQ-026 While reset=0, the block SHALL hold:
- FSM = IDLE;
- pointers and occupancy = 0;
- mem_req = 0, mem_addr = 0, mem_wdata = 0;
- StallM = 0.
REQ-027 Reset during BUSY SHALL drop mem_req immediately and discard all buffered stores; no partial drain resumes afterwards.
REQ-028 Buffer data storage need not be reset.

Configuration
REQ-029 Macro DMEM_FWD_EN SHALL select how a load that matches a buffered store is handled.
- Defined: ReadData SHALL return data from the youngest matching buffered entry, else mem_rdata; StallM is driven per REQ-018 only.
- Undefined: while any buffered entry matches ALUResult and MemWriteM=0, StallM SHALL be 1 until no match remains; ReadData SHALL always equal mem_rdata.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Store 0xDEADBEEF to 0x100, mem_ack high every cycle -> mem_req=1 with mem_addr=0x100, mem_wdata=0xDEADBEEF on cycle 2; FSM returns to IDLE on cycle 3.
- Five back-to-back stores to 0x0,0x4,...,0x10 (DEPTH=4), mem_ack held 0 -> StallM=1 on the fifth store; after one mem_ack, the fifth store is accepted and drain order is 0x0,0x4,0x8,0xC,0x10.
- Stores 0x11111111 then 0x22222222 to 0x40, then load 0x42, mem_ack=0 -> with DMEM_FWD_EN, ReadData=0x22222222 and StallM=0; without it, StallM=1 until both entries drain, then ReadData=mem_rdata.
- mem_ack pulsed every third cycle over 8 stores -> each mem_addr/mem_wdata stays stable while mem_req=1 and unacked; exactly 8 handshakes occur.
- Assert reset=0 mid-drain with 3 entries buffered -> mem_req falls immediately, with no clk edge needed; after release no requests issue and StallM=0.
- Push and ack in the same cycle with the FIFO at 2 entries -> occupancy remains 2 and the pointers wrap correctly across 10 iterations.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory store buffer with in-order drain to backing memory.
// A DEPTH-entry FIFO absorbs core stores and a two-state drain FSM writes them out
// one handshake at a time. Loads read backing memory directly.
// Build option: define DMEM_FWD_EN to forward load data from the youngest matching
// buffered store; when undefined, a load that hits a buffered store stalls until
// that store has drained.
module dmem_responder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MemWriteM,
   input  logic [AW-1:0] ALUResult,
   input  logic [31:0]   WriteData,
   output logic [31:0]   ReadData,
   output logic          StallM,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_raddr,
   input  logic [31:0]   mem_rdata
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = AW - 2;

   typedef struct packed {
      logic [WW-1:0] waddr;
      logic [31:0]   data;
   } entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        fifo_q [DEPTH];
   entry_t        head;
   logic          full;
   logic          push;
   logic          pop;
   logic [WW-1:0] req_waddr;

   assign req_waddr = ALUResult[AW-1:2];
   assign full      = (count_q == CW'(DEPTH));
   assign head      = fifo_q[rptr_q];
   assign mem_raddr = ALUResult;

   // Drain port is driven only while BUSY so it reads as zero in IDLE and in reset.
   assign mem_req   = (state_q == BUSY);
   assign mem_addr  = mem_req ? {head.waddr, 2'b00} : '0;
   assign mem_wdata = mem_req ? head.data : '0;

`ifdef DMEM_FWD_EN
   logic [31:0]   fwd_data;
   logic [PW-1:0] fwd_idx;

   // Scan oldest to youngest so the youngest matching store wins.
   always_comb begin
      fwd_data = mem_rdata;
      fwd_idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = rptr_q + PW'(i);
         if ((CW'(i) < count_q) && (fifo_q[fwd_idx].waddr == req_waddr)) begin
            fwd_data = fifo_q[fwd_idx].data;
         end
      end
   end

   assign ReadData = fwd_data;
   assign StallM   = MemWriteM & full;
`else
   logic          match_any;
   logic [PW-1:0] match_idx;

   // Flag any valid buffered entry whose word address equals the request.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         match_idx = rptr_q + PW'(i);
         if ((CW'(i) < count_q) && (fifo_q[match_idx].waddr == req_waddr)) begin
            match_any = 1'b1;
         end
      end
   end

   assign ReadData = mem_rdata;
   assign StallM   = (MemWriteM & full) | (~MemWriteM & match_any);
`endif

   // Next-state: FIFO bookkeeping and drain FSM; BUSY exactly while entries remain.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      push    = MemWriteM & ~StallM;
      pop     = (state_q == BUSY) & mem_ack;

      if (push) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE:    if (count_d != '0) state_d = BUSY;
         BUSY:    if (count_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset discards every buffered store.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage is written on push only and carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wptr_q] <= {req_waddr, WriteData};
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed stimulus against a queue-based model.
// Honours DMEM_FWD_EN the same way as the design.
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          MemWriteM;
   logic [AW-1:0] ALUResult;
   logic [31:0]   WriteData;
   logic [31:0]   ReadData;
   logic          StallM;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ack;
   logic [AW-1:0] mem_raddr;
   logic [31:0]   mem_rdata;

   typedef struct {
      logic [29:0] wa;
      logic [31:0] d;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] hs_log[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          hs_cnt  = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr, prev_wd;

   dmem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWriteM (MemWriteM),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .StallM    (StallM),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rmem(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
   endfunction

   assign mem_rdata = rmem(mem_raddr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rdata();
      logic [31:0] r;
      r = rmem(ALUResult);
`ifdef DMEM_FWD_EN
      foreach (exp_q[i]) if (exp_q[i].wa == ALUResult[31:2]) r = exp_q[i].d;
`endif
      return r;
   endfunction

   function automatic logic exp_stall();
      logic s;
      s = MemWriteM && (exp_q.size() == DEPTH);
`ifndef DMEM_FWD_EN
      if (!MemWriteM) foreach (exp_q[i]) if (exp_q[i].wa == ALUResult[31:2]) s = 1'b1;
`endif
      return s;
   endfunction

   // Reference model: a store is accepted unless stalled; a handshake retires the oldest.
   always @(posedge clk) begin
      ent_t e;
      logic acc, pp;
      if (!reset) begin
         exp_q.delete();
      end else begin
         acc = MemWriteM && !exp_stall();
         pp  = (exp_q.size() != 0) && mem_ack;
         if (pp) exp_q.delete(0);
         if (acc) begin
            e.wa = ALUResult[31:2];
            e.d  = WriteData;
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: compares every DUT output against the model mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         chk("rst_stall", {31'd0, StallM}, 32'd0);
         prev_hold = 1'b0;
      end else begin
         chk("mem_req", {31'd0, mem_req}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) begin
            chk("mem_addr", mem_addr, {exp_q[0].wa, 2'b00});
            chk("mem_wdata", mem_wdata, exp_q[0].d);
         end
         if (prev_hold && mem_req) begin
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_wdata", mem_wdata, prev_wd);
         end
         chk("stall", {31'd0, StallM}, {31'd0, exp_stall()});
         chk("read_data", ReadData, exp_rdata());
         chk("mem_raddr", mem_raddr, ALUResult);
         if (mem_req && mem_ack) begin
            hs_cnt++;
            hs_log.push_back(mem_addr);
         end
         prev_hold = mem_req && !mem_ack;
         prev_addr = mem_addr;
         prev_wd   = mem_wdata;
      end
   end

   task automatic setin(input logic we, input logic [31:0] a, input logic [31:0] d, input logic ack);
      MemWriteM = we;
      ALUResult = a;
      WriteData = d;
      mem_ack   = ack;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      setin(1'b0, 32'h8000_0000, 32'd0, 1'b1);
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
      end
      step();
   endtask

   initial begin
      int n, cyc;
      int hs0;
      logic [31:0] a;

      reset = 1'b0;
      setin(1'b0, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      step();

      // Single store, ack always high: request on cycle 2, idle on cycle 3.
      setin(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
      #3 chk("s1_stall", {31'd0, StallM}, 32'd0);
      step();
      setin(1'b0, 32'h0, 32'd0, 1'b1);
      #3 chk("s1_req_c2", {31'd0, mem_req}, 32'd1);
      chk("s1_addr_c2", mem_addr, 32'h100);
      chk("s1_wdata_c2", mem_wdata, 32'hDEAD_BEEF);
      step();
      #3 chk("s1_req_c3", {31'd0, mem_req}, 32'd0);
      step();

      // Fill to DEPTH, stall the fifth store, accept it after one ack.
      hs_log.delete();
      for (int k = 0; k < 4; k++) begin
         setin(1'b1, 32'(4 * k), 32'hA0 + 32'(k), 1'b0);
         step();
      end
      setin(1'b1, 32'h10, 32'hA4, 1'b0);
      #3 chk("s2_stall_full", {31'd0, StallM}, 32'd1);
      step();
      setin(1'b1, 32'h10, 32'hA4, 1'b1);
      #3 chk("s2_stall_with_pop", {31'd0, StallM}, 32'd1);
      step();
      setin(1'b1, 32'h10, 32'hA4, 1'b0);
      #3 chk("s2_stall_released", {31'd0, StallM}, 32'd0);
      step();
      drain();
      chk("s2_hs_count", 32'(hs_log.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         a = (k < hs_log.size()) ? hs_log[k] : 32'hFFFF_FFFF;
         chk("s2_drain_order", a, 32'(4 * k));
      end

      // Two stores to the same word, then a load of that word.
      setin(1'b1, 32'h40, 32'h1111_1111, 1'b0);
      step();
      setin(1'b1, 32'h40, 32'h2222_2222, 1'b0);
      step();
      setin(1'b0, 32'h42, 32'd0, 1'b0);
      #3;
`ifdef DMEM_FWD_EN
      chk("s3_fwd_data", ReadData, 32'h2222_2222);
      chk("s3_fwd_stall", {31'd0, StallM}, 32'd0);
`else
      chk("s3_hit_stall", {31'd0, StallM}, 32'd1);
      chk("s3_hit_data", ReadData, rmem(32'h42));
`endif
      step();
      step();
      setin(1'b0, 32'h42, 32'd0, 1'b1);
      step();
      step();
      #3 chk("s3_after_stall", {31'd0, StallM}, 32'd0);
      chk("s3_after_data", ReadData, rmem(32'h42));
      step();

      // Eight stores with ack every third cycle.
      hs0 = hs_cnt;
      n   = 0;
      cyc = 0;
      while ((n < 8 || exp_q.size() != 0) && cyc < 200) begin
         if (n < 8) begin
            setin(1'b1, 32'h200 + 32'(4 * n), $urandom, (cyc % 3) == 2);
            if (exp_q.size() < DEPTH) n++;
         end else begin
            setin(1'b0, 32'h8000_0000, 32'd0, (cyc % 3) == 2);
         end
         step();
         cyc++;
      end
      step();
      chk("s4_handshakes", 32'(hs_cnt - hs0), 32'd8);

      // Reset in the middle of a drain with three entries buffered.
      for (int k = 0; k < 3; k++) begin
         setin(1'b1, 32'h300 + 32'(4 * k), $urandom, 1'b0);
         step();
      end
      setin(1'b0, 32'h8000_0000, 32'd0, 1'b0);
      #1 chk("s5_req_before", {31'd0, mem_req}, 32'd1);
      #1 reset = 1'b0;
      exp_q.delete();
      #1 chk("s5_req_async_drop", {31'd0, mem_req}, 32'd0);
      chk("s5_stall_in_reset", {31'd0, StallM}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      hs0 = hs_cnt;
      setin(1'b0, 32'h300, 32'd0, 1'b1);
      repeat (5) step();
      chk("s5_no_resume", 32'(hs_cnt - hs0), 32'd0);

      // Hold occupancy at two with simultaneous push and pop across pointer wrap.
      setin(1'b1, 32'h500, 32'h5000_0000, 1'b0);
      step();
      setin(1'b1, 32'h504, 32'h5000_0001, 1'b0);
      step();
      for (int i = 0; i < 10; i++) begin
         setin(1'b1, 32'h508 + 32'(4 * i), $urandom, 1'b1);
         #3 chk("s6_no_stall", {31'd0, StallM}, 32'd0);
         step();
      end
      setin(1'b1, 32'h600, 32'h6000_0000, 1'b0);
      step();
      setin(1'b1, 32'h604, 32'h6000_0001, 1'b0);
      step();
      setin(1'b1, 32'h608, 32'h6000_0002, 1'b0);
      #3 chk("s6_full_after_wrap", {31'd0, StallM}, 32'd1);
      step();
      drain();

      // Random mix over a small address window to provoke hits and stalls.
      for (int i = 0; i < 400; i++) begin
         setin(1'($urandom_range(0, 1)),
               32'h700 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
               $urandom, 1'($urandom_range(0, 1)));
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
